prf_ready_file: RTL and testbench

Physical register file with per-register ready bits, sitting directly downstream of the FU/CDB stage. It consumes the `N` CDB broadcasts each cycle, writes their results into physical registers and marks them ready. Issue and dispatch logic read operand values and ready state from it. Dispatch clears ready bits on newly allocated destination registers, and a squash marks every register ready.

---
 rtl/prf_ready_file.sv | 117 +++++++++++
 tb/tb_prf_ready_file.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/prf_ready_file.sv
// Physical register file with per-register ready bits, fed by N CDB ports; optional CDB read bypass under PRF_CDB_BYPASS_EN.
// Latency: writes/allocations visible one cycle after the edge, reads combinational; num_pending registered.
// Backpressure: none, every CDB broadcast and allocation is accepted every cycle.
`ifndef N
`define N 2
`endif

module prf_ready_file #(
    parameter int N           = `N,
    parameter int PHYS_REG_SZ = 64,
    parameter int NUM_RD      = 2 * N,
    localparam int PRW        = $clog2(PHYS_REG_SZ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [N-1:0]          cdb_valid,
    input  logic [N*PRW-1:0]      cdb_preg,
    input  logic [N*32-1:0]       cdb_value,
    input  logic [N-1:0]          alloc_valid,
    input  logic [N*PRW-1:0]      alloc_preg,
    input  logic [NUM_RD*PRW-1:0] rd_preg,
    output logic [NUM_RD*32-1:0]  rd_value,
    output logic [NUM_RD-1:0]     rd_ready,
    output logic [PRW:0]          num_pending
);

    logic [31:0]            value [PHYS_REG_SZ];
    logic [PHYS_REG_SZ-1:0] ready;
    logic [PHYS_REG_SZ-1:0] ready_nxt;
    logic [PRW:0]           pend_nxt;

    logic [PRW-1:0] cdb_pa   [N];
    logic [31:0]    cdb_da   [N];
    logic [PRW-1:0] alloc_pa [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cdb_pa[i]   = cdb_preg[i*PRW +: PRW];
            cdb_da[i]   = cdb_value[i*32 +: 32];
            alloc_pa[i] = alloc_preg[i*PRW +: PRW];
        end
    end

    // Allocation is applied after CDB so it wins a same-cycle collision on the ready bit.
    always_comb begin
        ready_nxt = ready;
        if (squash) begin
            ready_nxt = '1;
        end
        for (int i = 0; i < N; i++) begin
            if (cdb_valid[i]) begin
                ready_nxt[cdb_pa[i]] = 1'b1;
            end
        end
        if (!squash) begin
            for (int i = 0; i < N; i++) begin
                if (alloc_valid[i]) begin
                    ready_nxt[alloc_pa[i]] = 1'b0;
                end
            end
        end
        ready_nxt[0] = 1'b1;
    end

    // Counting the next ready vector keeps num_pending locked to the real not-ready population.
    always_comb begin
        pend_nxt = '0;
        for (int r = 1; r < PHYS_REG_SZ; r++) begin
            pend_nxt = pend_nxt + {{PRW{1'b0}}, ~ready_nxt[r]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < PHYS_REG_SZ; r++) begin
                value[r] <= '0;
            end
            ready       <= '1;
            num_pending <= '0;
        end else begin
            ready       <= ready_nxt;
            num_pending <= pend_nxt;
            // Descending order: the last non-blocking write lands, so the lowest port wins.
            for (int i = N - 1; i >= 0; i--) begin
                if (cdb_valid[i] && (cdb_pa[i] != '0)) begin
                    value[cdb_pa[i]] <= cdb_da[i];
                end
            end
        end
    end

    function automatic logic [32:0] read_port(input logic [PRW-1:0] idx);
        logic [32:0] res;
        res = {ready[idx], value[idx]};
`ifdef PRF_CDB_BYPASS_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (cdb_pa[i] == idx)) begin
                res = {1'b1, cdb_da[i]};
            end
        end
`endif
        if (idx == '0) begin
            res = {1'b1, 32'h0};
        end
        return res;
    endfunction

    always_comb begin
        rd_value = '0;
        rd_ready = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            {rd_ready[k], rd_value[k*32 +: 32]} = read_port(rd_preg[k*PRW +: PRW]);
        end
    end

endmodule

// File: tb/tb_prf_ready_file.sv
// Directed table-driven bench for prf_ready_file (N=2, 64 registers, 4 read ports).
module tb_prf_ready_file;

`ifdef PRF_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clock;
    logic         reset;
    logic         squash;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_preg;
    logic [63:0]  cdb_value;
    logic [1:0]   alloc_valid;
    logic [11:0]  alloc_preg;
    logic [23:0]  rd_preg;
    logic [127:0] rd_value;
    logic [3:0]   rd_ready;
    logic [6:0]   num_pending;

    int tests = 0;
    int fails = 0;

    prf_ready_file #(.N(2), .PHYS_REG_SZ(64), .NUM_RD(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .cdb_valid   (cdb_valid),
        .cdb_preg    (cdb_preg),
        .cdb_value   (cdb_value),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .rd_preg     (rd_preg),
        .rd_value    (rd_value),
        .rd_ready    (rd_ready),
        .num_pending (num_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        sq;
        logic [1:0]  cv;
        logic [5:0]  cp0;
        logic [31:0] cd0;
        logic [5:0]  cp1;
        logic [31:0] cd1;
        logic [1:0]  av;
        logic [5:0]  ap0;
        logic [5:0]  ap1;
        logic [5:0]  r0;
        logic [5:0]  r1;
        logic [31:0] v0;
        logic        y0;
        logic [31:0] v1;
        logic        y1;
        logic [6:0]  np;
    } rec_t;

    rec_t vecs[$];

    function automatic rec_t mk(
        input logic rst, input logic sq,
        input logic [1:0] cv, input logic [5:0] cp0, input logic [31:0] cd0,
        input logic [5:0] cp1, input logic [31:0] cd1,
        input logic [1:0] av, input logic [5:0] ap0, input logic [5:0] ap1,
        input logic [5:0] r0, input logic [5:0] r1,
        input logic [31:0] v0, input logic y0, input logic [31:0] v1, input logic y1,
        input logic [6:0] np);
        rec_t r;
        r.rst = rst; r.sq = sq; r.cv = cv; r.cp0 = cp0; r.cd0 = cd0; r.cp1 = cp1; r.cd1 = cd1;
        r.av = av; r.ap0 = ap0; r.ap1 = ap1; r.r0 = r0; r.r1 = r1;
        r.v0 = v0; r.y0 = y0; r.v1 = v1; r.y1 = y1; r.np = np;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
        end
    endtask

    task automatic drive(input rec_t r);
        reset       = r.rst;
        squash      = r.sq;
        cdb_valid   = r.cv;
        cdb_preg    = {r.cp1, r.cp0};
        cdb_value   = {r.cd1, r.cd0};
        alloc_valid = r.av;
        alloc_preg  = {r.ap1, r.ap0};
        rd_preg     = {6'd0, 6'd0, r.r1, r.r0};
    endtask

    initial begin
        rec_t idle;
        // rst sq  cv    cp0  cd0           cp1  cd1    av    ap0  ap1  r0   r1   v0 y0 v1 y1 np
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  0,   5,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  63,  0,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b01, 7,  0,  7,   5,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  7,   0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0,0,2'b01, 7, 32'hDEADBEEF,  0, 0,    2'b00, 0,  0,  7,   7,
                          BYP ? 32'hDEADBEEF : 32'h0, BYP, BYP ? 32'hDEADBEEF : 32'h0, BYP, 1));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  7,   0,  32'hDEADBEEF, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b01, 9, 32'h1234,      0, 0,    2'b00, 0,  0,  9,   7,
                          BYP ? 32'h1234 : 32'h0, 1, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  9,   0,  32'h1234, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b11, 12, 32'hA,        12, 32'hB, 2'b00, 0, 0,  12,  9,
                          BYP ? 32'hA : 32'h0, 1, 32'h1234, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  12,  12, 32'hA, 1, 32'hA, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b11, 3,  4,  3,   4,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b01, 5,  0,  3,   4,  0, 0, 0, 0, 2));
        vecs.push_back(mk(0,1,2'b00, 0, 0,             0, 0,    2'b10, 0,  6,  5,   6,  0, 0, 0, 1, 3));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  5,   6,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  3,   4,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b01, 0, 32'hFF,        0, 0,    2'b01, 0,  0,  0,   0,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  0,   12, 0, 1, 32'hA, 1, 0));
        vecs.push_back(mk(0,0,2'b01, 20, 32'h55,       0, 0,    2'b01, 20, 0,  20,  0,
                          BYP ? 32'h55 : 32'h0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  20,  0,  32'h55, 0, 0, 1, 1));
        vecs.push_back(mk(0,1,2'b10, 0, 0,             21, 32'h77, 2'b00, 0, 0, 20,  21,
                          32'h55, 0, BYP ? 32'h77 : 32'h0, 1, 1));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  20,  21, 32'h55, 1, 32'h77, 1, 0));
        vecs.push_back(mk(1,0,2'b01, 31, 32'h99,       0, 0,    2'b10, 0,  30, 7,   31,
                          32'hDEADBEEF, 1, BYP ? 32'h99 : 32'h0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  7,   31, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,2'b00, 0, 0,             0, 0,    2'b00, 0,  0,  30,  9,  0, 1, 0, 1, 0));

        idle = mk(0,0,2'b00,0,0,0,0,2'b00,0,0,0,0,0,1,0,1,0);
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            chk("rd0_value", i, rd_value[31:0], vecs[i].v0);
            chk("rd0_ready", i, {31'h0, rd_ready[0]}, {31'h0, vecs[i].y0});
            chk("rd1_value", i, rd_value[63:32], vecs[i].v1);
            chk("rd1_ready", i, {31'h0, rd_ready[1]}, {31'h0, vecs[i].y1});
            chk("num_pending", i, {25'h0, num_pending}, {25'h0, vecs[i].np});
        end

        // Allocation through port 1 stays pending across idle cycles, then both CDB ports hit it.
        @(negedge clock);
        drive(idle);
        alloc_valid = 2'b10;
        alloc_preg  = {6'd40, 6'd0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(idle);
            rd_preg = {6'd9, 6'd40, 6'd0, 6'd0};
            #1;
            chk("seq_pend_ready", 100 + c, {31'h0, rd_ready[2]}, 32'h0);
            chk("seq_pend_count", 100 + c, {25'h0, num_pending}, 32'h1);
        end
        @(negedge clock);
        drive(idle);
        cdb_valid = 2'b11;
        cdb_preg  = {6'd40, 6'd40};
        cdb_value = {32'hCAFE, 32'h1111};
        @(negedge clock);
        drive(idle);
        rd_preg = {6'd9, 6'd40, 6'd0, 6'd0};
        #1;
        chk("seq_write_value", 110, rd_value[95:64], 32'h1111);
        chk("seq_write_ready", 110, {31'h0, rd_ready[2]}, 32'h1);
        chk("seq_port3_value", 110, rd_value[127:96], 32'h0);
        chk("seq_write_count", 110, {25'h0, num_pending}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
